// File: rtl/pq_rr_arb_if.sv
// Request/grant bundle between per-requester queues and the round-robin arbiter.
// The master side drives requests and downstream ready; the slave (arbiter) drives the grant.
interface pq_rr_arb_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] req_vec;
    logic [WIDTH-1:0] req_last_vec;
    logic             ready;
    logic             ack_valid;
    logic [WIDTH-1:0] ack_one_hot;
    logic [IDX_W-1:0] ack_index;
    logic             locked;

    modport master (
        output req_vec,
        output req_last_vec,
        output ready,
        input  ack_valid,
        input  ack_one_hot,
        input  ack_index,
        input  locked
    );

    modport slave (
        input  req_vec,
        input  req_last_vec,
        input  ready,
        output ack_valid,
        output ack_one_hot,
        output ack_index,
        output locked
    );
endinterface

// File: rtl/pq_rr_arb.sv
// Round-robin arbiter with transaction locking: zero-latency grant from a masked/unmasked
// find-first-set pair, held across multi-beat transactions until the last beat transfers.
module pq_rr_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input logic        CLK,
    input logic        RST,
    pq_rr_arb_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prio_mask_q, prio_mask_d;
    logic [WIDTH-1:0] lock_q, lock_d;

    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] masked_req;
    logic [WIDTH-1:0] masked_lsb;
    logic [WIDTH-1:0] plain_lsb;
    logic [WIDTH-1:0] win;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             xfer;
    logic             win_last;
    logic             lock_held;
    logic [WIDTH-1:0] above_win;
    logic [WIDTH-1:0] above_lock;

    assign req        = bus.req_vec;
    assign masked_req = req & prio_mask_q;

    // x & -x isolates the lowest set bit.
    assign masked_lsb = masked_req & (~masked_req + One);
    assign plain_lsb  = req & (~req + One);

    assign lock_held  = |(req & lock_q);

    always_comb begin
        win = '0;
        unique case (state_q)
            StIdle:   win = (|masked_req) ? masked_lsb : plain_lsb;
            StLocked: win = lock_held ? lock_q : '0;
            default:  win = '0;
        endcase
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (win[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign win_valid = |win;
    assign xfer      = win_valid & bus.ready;
    assign win_last  = |(win & bus.req_last_vec);

    // Thermometer of bits strictly above a one-hot vector; all zeros at the top index.
    assign above_win  = ~(win | (win - One));
    assign above_lock = ~(lock_q | (lock_q - One));

    always_comb begin
        state_d     = state_q;
        prio_mask_d = prio_mask_q;
        lock_d      = lock_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (win_last) begin
                        prio_mask_d = above_win;
                    end else begin
                        state_d = StLocked;
                        lock_d  = win;
                    end
                end
            end
            StLocked: begin
                // Last beat and abort both release the lock and rotate past the holder.
                if ((xfer && win_last) || !lock_held) begin
                    state_d     = StIdle;
                    prio_mask_d = above_lock;
                    lock_d      = '0;
                end
            end
            default: begin
                state_d     = StIdle;
                prio_mask_d = '1;
                lock_d      = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            prio_mask_q <= '1;
            lock_q      <= '0;
        end else begin
            state_q     <= state_d;
            prio_mask_q <= prio_mask_d;
            lock_q      <= lock_d;
        end
    end

    assign bus.ack_valid   = win_valid;
    assign bus.ack_one_hot = win;
    assign bus.ack_index   = win_idx;
    assign bus.locked      = (state_q == StLocked);

endmodule

// File: tb/tb_pq_rr_arb.sv
// Directed bench for pq_rr_arb: rotation, wrap, locking, backpressure, abort and reset.
module tb_pq_rr_arb;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pq_rr_arb_if #(.WIDTH(8)) bus ();

    pq_rr_arb #(.WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_vec = 8'h00;
        bus.req_last_vec = 8'hFF;
        bus.ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_vec = 8'hFF;
        bus.req_last_vec = 8'hFF;
        bus.ready = 1'b1;
        tick();
        checks++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_locked: got %b expected 0", bus.locked);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ack_one_hot !== 8'h01) begin
            failures++;
            $display("FAIL reset_onehot: got %h expected 01", bus.ack_one_hot);
        end
        checks++;
        if (bus.ack_index !== 3'd0) begin
            failures++;
            $display("FAIL reset_index: got %0d expected 0", bus.ack_index);
        end
        bus.req_vec = 8'h00;
        #1;
        checks++;
        if (bus.ack_valid !== 1'b0 || bus.ack_one_hot !== 8'h00 || bus.ack_index !== 3'd0) begin
            failures++;
            $display("FAIL idle_outputs: got v=%b oh=%h idx=%0d expected 0/00/0",
                     bus.ack_valid, bus.ack_one_hot, bus.ack_index);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] e;
        do_reset();
        bus.req_vec = 8'hFF;
        bus.req_last_vec = 8'hFF;
        bus.ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e = 3'(i % 8);
            #1;
            checks++;
            if (bus.ack_index !== e || bus.ack_one_hot !== (8'h01 << e)) begin
                failures++;
                $display("FAIL rotation[%0d]: got idx=%0d oh=%h expected idx=%0d",
                         i, bus.ack_index, bus.ack_one_hot, e);
            end
            tick();
        end
    endtask

    task automatic test_sparse_wrap();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd2;
        exp_seq[1] = 3'd7;
        exp_seq[2] = 3'd2;
        exp_seq[3] = 3'd7;
        do_reset();
        bus.req_vec = 8'b1000_0100;
        bus.req_last_vec = 8'hFF;
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.ack_index !== exp_seq[i] || bus.ack_valid !== 1'b1) begin
                failures++;
                $display("FAIL sparse[%0d]: got idx=%0d v=%b expected idx=%0d",
                         i, bus.ack_index, bus.ack_valid, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_lock_hold();
        logic       rdy_seq  [4];
        logic       last_seq [4];
        logic       lock_exp [4];
        rdy_seq[0] = 1'b1; last_seq[0] = 1'b0; lock_exp[0] = 1'b0;
        rdy_seq[1] = 1'b0; last_seq[1] = 1'b0; lock_exp[1] = 1'b1;
        rdy_seq[2] = 1'b1; last_seq[2] = 1'b0; lock_exp[2] = 1'b1;
        rdy_seq[3] = 1'b1; last_seq[3] = 1'b1; lock_exp[3] = 1'b1;
        do_reset();
        // Single-beat grant to 0 moves priority to requester 1.
        bus.req_vec = 8'h0F;
        bus.req_last_vec = 8'hFF;
        bus.ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.ready = rdy_seq[i];
            bus.req_last_vec = last_seq[i] ? 8'hFF : 8'h00;
            #1;
            checks++;
            if (bus.ack_one_hot !== 8'h02 || bus.locked !== lock_exp[i]) begin
                failures++;
                $display("FAIL lock_beat[%0d]: got oh=%h lk=%b expected oh=02 lk=%b",
                         i, bus.ack_one_hot, bus.locked, lock_exp[i]);
            end
            tick();
        end
        bus.req_last_vec = 8'hFF;
        #1;
        checks++;
        if (bus.locked !== 1'b0 || bus.ack_index !== 3'd2) begin
            failures++;
            $display("FAIL lock_release: got lk=%b idx=%0d expected lk=0 idx=2",
                     bus.locked, bus.ack_index);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req_vec = 8'h30;
        bus.req_last_vec = 8'hFF;
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.ack_one_hot !== 8'h10 || bus.locked !== 1'b0) begin
                failures++;
                $display("FAIL backpressure[%0d]: got oh=%h lk=%b expected oh=10 lk=0",
                         i, bus.ack_one_hot, bus.locked);
            end
            tick();
        end
        bus.ready = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.ack_index !== 3'd5) begin
            failures++;
            $display("FAIL backpressure_after: got idx=%0d expected 5", bus.ack_index);
        end
    endtask

    task automatic test_lock_abort();
        do_reset();
        bus.req_vec = 8'h20;
        bus.req_last_vec = 8'h00;
        bus.ready = 1'b1;
        tick();
        // Another requester with ready low must not steal the lock.
        bus.req_vec = 8'h60;
        bus.ready = 1'b0;
        #1;
        checks++;
        if (bus.ack_one_hot !== 8'h20 || bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_keep: got oh=%h lk=%b expected oh=20 lk=1",
                     bus.ack_one_hot, bus.locked);
        end
        tick();
        bus.req_vec = 8'h40;
        bus.ready = 1'b1;
        #1;
        checks++;
        if (bus.ack_valid !== 1'b0 || bus.ack_one_hot !== 8'h00 || bus.ack_index !== 3'd0 ||
            bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL abort_cycle: got v=%b oh=%h idx=%0d lk=%b expected 0/00/0/1",
                     bus.ack_valid, bus.ack_one_hot, bus.ack_index, bus.locked);
        end
        tick();
        bus.req_vec = 8'h43;
        bus.req_last_vec = 8'hFF;
        #1;
        checks++;
        if (bus.locked !== 1'b0 || bus.ack_index !== 3'd6) begin
            failures++;
            $display("FAIL abort_next: got lk=%b idx=%0d expected lk=0 idx=6",
                     bus.locked, bus.ack_index);
        end
    endtask

    task automatic test_reset_locked();
        do_reset();
        bus.req_vec = 8'h08;
        bus.req_last_vec = 8'h00;
        bus.ready = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL rst_lock_setup: got lk=%b expected 1", bus.locked);
        end
        bus.req_vec = 8'hFF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.locked !== 1'b0 || bus.ack_index !== 3'd0) begin
            failures++;
            $display("FAIL rst_locked: got lk=%b idx=%0d expected lk=0 idx=0",
                     bus.locked, bus.ack_index);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.req_vec = 8'h00;
        bus.req_last_vec = 8'h00;
        bus.ready = 1'b0;
        test_reset();
        test_rotation();
        test_sparse_wrap();
        test_lock_hold();
        test_backpressure();
        test_lock_abort();
        test_reset_locked();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
